// File: rtl/button_input_conditioner.sv
// Push-button front end: two-flop sync, per-channel debounce FSM, press/release/strobe pulses.
// Optional auto-repeat on btn_strobe is built when the AUTOREPEAT_EN macro is defined.
module button_input_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk_osc,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_strobe,
  output logic             any_press
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_SAT) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic [N_BTN-1:0] sync_d_r;
  logic [N_BTN-1:0] sync_q_r;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      sync_d_r <= {N_BTN{1'b0}};
      sync_q_r <= {N_BTN{1'b0}};
    end else begin
      sync_d_r <= btn_raw;
      sync_q_r <= sync_d_r;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             press_evt_s;

    assign press_evt_s = (state_r == PRESS_CHK) && sync_q_r[i] && (cnt_r == DEB_LAST);

    // Debounce FSM; pulses coincide with the level change and are dropped while disabled
    always_ff @(posedge clk_osc or negedge reset) begin
      if (!reset) begin
        state_r   <= IDLE;
        cnt_r     <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_r)
          IDLE: begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            if (sync_q_r[i]) begin
              state_r <= PRESS_CHK;
            end else begin
              state_r <= IDLE;
            end
          end
          PRESS_CHK: begin
            if (!sync_q_r[i]) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else if (cnt_r == DEB_LAST) begin
              state_r <= HELD;
              cnt_r   <= '0;
              level_r <= 1'b1;
              press_r <= enable;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          HELD: begin
            cnt_r   <= '0;
            level_r <= 1'b1;
            if (!sync_q_r[i]) begin
              state_r <= REL_CHK;
            end else begin
              state_r <= HELD;
            end
          end
          REL_CHK: begin
            if (sync_q_r[i]) begin
              state_r <= HELD;
              cnt_r   <= '0;
            end else if (cnt_r == DEB_LAST) begin
              state_r   <= IDLE;
              cnt_r     <= '0;
              level_r   <= 1'b0;
              release_r <= enable;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            level_r <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rpt_cnt_r;
    logic             rpt_first_r;
    logic             strobe_r;
    logic             in_hold_s;
    logic             rpt_fire_s;

    // First repeat uses the long delay, later ones the shorter rate
    always_comb begin
      in_hold_s  = (state_r == HELD) || (state_r == REL_CHK);
      rpt_fire_s = 1'b0;
      if (in_hold_s) begin
        if (rpt_first_r) begin
          rpt_fire_s = (rpt_cnt_r == RATE_LAST);
        end else begin
          rpt_fire_s = (rpt_cnt_r == DELAY_LAST);
        end
      end else begin
        rpt_fire_s = 1'b0;
      end
    end

    // Repeat counter runs only while held; it is already clear on the press edge
    always_ff @(posedge clk_osc or negedge reset) begin
      if (!reset) begin
        rpt_cnt_r   <= '0;
        rpt_first_r <= 1'b0;
        strobe_r    <= 1'b0;
      end else begin
        strobe_r <= enable & (press_evt_s | rpt_fire_s);
        if (!in_hold_s) begin
          rpt_cnt_r   <= '0;
          rpt_first_r <= 1'b0;
        end else if (rpt_fire_s) begin
          rpt_cnt_r   <= '0;
          rpt_first_r <= 1'b1;
        end else begin
          rpt_cnt_r <= sat_inc(rpt_cnt_r);
        end
      end
    end

    assign btn_strobe[i] = strobe_r;
`else
    logic unused_evt_s;
    assign unused_evt_s  = press_evt_s;
    assign btn_strobe[i] = press_r;
`endif
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner with a cycle-stamped pulse scoreboard.
module tb_button_input_conditioner;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;
  localparam int LAT = 3 + DEB;  // drive after edge k -> output seen after edge k+LAT

  logic          clk_osc = 1'b0;
  logic          reset;
  logic          enable;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_strobe;
  logic          any_press;

  button_input_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_osc(clk_osc), .reset(reset), .enable(enable), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_strobe(btn_strobe), .any_press(any_press)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] strobe;
    logic [NB-1:0] level;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  int            p;
  logic [NB-1:0] exp_level = '0;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_exp(input int c, input logic [NB-1:0] pr, input logic [NB-1:0] rl,
                          input logic [NB-1:0] st, input logic [NB-1:0] lv);
    exp_t e;
    e.cyc = c; e.press = pr; e.rel = rl; e.strobe = st; e.level = lv;
    sb.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t          e;
    logic [NB-1:0] ep, er, es;
    ep = '0; er = '0; es = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      ep = e.press; er = e.rel; es = e.strobe;
      exp_level = e.level;
    end
    chk("press", btn_press, ep);
    chk("release", btn_release, er);
    chk("strobe", btn_strobe, es);
    chk("any_press", {4'b0000, any_press}, {4'b0000, |ep});
    chk("level", btn_level, exp_level);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_osc);
      #1;
      cyc++;
      check_outputs();
    end
  endtask

  initial begin
    // Reset with every button held
    reset = 1'b0; enable = 1'b1; btn_raw = 5'b11111;
    #1;
    chk("rst_level", btn_level, 5'b00000);
    chk("rst_press", btn_press, 5'b00000);
    run_cycles(5);
    reset = 1'b1;
    push_exp(cyc + LAT, 5'b11111, 5'b00000, 5'b11111, 5'b11111);
    run_cycles(LAT);
    btn_raw = 5'b00000;
    push_exp(cyc + LAT, 5'b00000, 5'b11111, 5'b00000, 5'b00000);
    run_cycles(LAT + 2);

    // Bounce on channel 0: 3 high, 2 low, then steady high
    btn_raw[0] = 1'b1;
    run_cycles(3);
    btn_raw[0] = 1'b0;
    run_cycles(2);
    btn_raw[0] = 1'b1;
    push_exp(cyc + LAT, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    run_cycles(LAT + 2);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    run_cycles(LAT + 2);

    // Simultaneous press on channels 1 and 3
    btn_raw = 5'b01010;
    push_exp(cyc + LAT, 5'b01010, 5'b00000, 5'b01010, 5'b01010);
    run_cycles(LAT + 2);
    btn_raw = 5'b00000;
    push_exp(cyc + LAT, 5'b00000, 5'b01010, 5'b00000, 5'b00000);
    run_cycles(LAT + 2);

    // Press on channel 4 while disabled: level follows, pulse is lost
    enable = 1'b0;
    btn_raw[4] = 1'b1;
    push_exp(cyc + LAT, 5'b00000, 5'b00000, 5'b00000, 5'b10000);
    run_cycles(LAT + 2);
    chk("en_level4", {4'b0000, btn_level[4]}, 5'b00001);
    enable = 1'b1;
    run_cycles(5);
    btn_raw[4] = 1'b0;
    push_exp(cyc + LAT, 5'b00000, 5'b10000, 5'b00000, 5'b00000);
    run_cycles(LAT + 2);

    // Long hold on channel 2 for auto-repeat
    btn_raw[2] = 1'b1;
    p = cyc + LAT;
    push_exp(p, 5'b00100, 5'b00000, 5'b00100, 5'b00100);
`ifdef AUTOREPEAT_EN
    push_exp(p + RD, 5'b00000, 5'b00000, 5'b00100, 5'b00100);
    for (int k = 1; k <= 4; k++) begin
      push_exp(p + RD + RR * k, 5'b00000, 5'b00000, 5'b00100, 5'b00100);
    end
`endif
    run_cycles(LAT + 49);
    btn_raw[2] = 1'b0;
    push_exp(cyc + LAT, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
    run_cycles(LAT + 8);

    // Async reset while channel 0 is held: no release pulse, fresh press afterwards
    btn_raw[0] = 1'b1;
    push_exp(cyc + LAT, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    run_cycles(LAT + 2);
    chk("held_level0", btn_level, 5'b00001);
    reset = 1'b0;
    #1;
    chk("async_level", btn_level, 5'b00000);
    chk("async_release", btn_release, 5'b00000);
    exp_level = '0;
    run_cycles(3);
    reset = 1'b1;
    push_exp(cyc + LAT, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    run_cycles(LAT + 2);
    btn_raw[0] = 1'b0;
    push_exp(cyc + LAT, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    run_cycles(LAT + 2);

    chk("sb_drained", {4'b0000, sb.size() == 0}, 5'b00001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
